// File: rtl/fpu16_pkg.sv
// Shared definitions for the 16-bit FPU datapath.
//   - FP16 constants used by the reciprocal square root unit
//   - FSM state encoding for fast_inv_sqrt
//   - field extractors and a shared round-to-nearest-even pack helper
package fpu16_pkg;

  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  localparam logic [15:0] FP16_ONE_P5   = 16'h3E00;
  localparam logic [15:0] INVSQRT_MAGIC = 16'h59BB;

  localparam int unsigned NrIters = 2;

  typedef enum logic [2:0] {
    StLoad,
    StSeed,
    StSq,
    StMh,
    StSub,
    StMy,
    StFin
  } state_e;

  // Rounded FP16 value plus its range exception flags.
  typedef struct packed {
    logic [15:0] val;
    logic        of;
    logic        uf;
  } fp16_res_t;

  function automatic logic fp16_sign(input logic [15:0] v);
    return v[15];
  endfunction

  function automatic logic [4:0] fp16_exp(input logic [15:0] v);
    return v[14:10];
  endfunction

  function automatic logic [9:0] fp16_mant(input logic [15:0] v);
    return v[9:0];
  endfunction

  // Round a normalised significand (hidden bit at sig[10]) with RNE, then range-check the
  // biased exponent. Anything below the normal range flushes to zero and raises underflow.
  function automatic fp16_res_t fp16_round_pack(input logic              sign,
                                                input logic signed [9:0] exp_b,
                                                input logic [10:0]       sig,
                                                input logic              guard,
                                                input logic              sticky);
    fp16_res_t         res;
    logic [11:0]       sum;
    logic signed [9:0] e;
    res = '0;
    sum = {1'b0, sig} + {11'd0, guard & (sticky | sig[0])};
    e   = exp_b;
    if (sum[11]) begin
      sum = sum >> 1;
      e   = e + 10'sd1;
    end
    if (e >= 10'sd31) begin
      res.val = {sign, FP16_POS_INF[14:0]};
      res.of  = 1'b1;
    end else if (e <= 10'sd0) begin
      res.val = {sign, 15'd0};
      res.uf  = 1'b1;
    end else begin
      res.val = {sign, e[4:0], sum[9:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/fast_inv_sqrt_mul.sv
// fp16_mul: combinational FP16 multiplier, round-to-nearest-even.
// Subnormal operands are treated as zero; subnormal results flush to zero.
//   a_i, b_i : FP16 operands
//   p_o      : FP16 product
//   of_o     : product overflowed to infinity
//   uf_o     : nonzero product flushed to zero
module fp16_mul
  import fpu16_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] p_o,
  output logic        of_o,
  output logic        uf_o
);

  logic              sign;
  logic [4:0]        ea, eb;
  logic              a_zero, b_zero, a_spec, b_spec, a_nan, b_nan;
  logic [21:0]       prod;
  logic signed [9:0] ea_s, eb_s, exp_b;
  logic [10:0]       sig;
  logic              guard, sticky;
  fp16_res_t         rp;

  assign sign   = fp16_sign(a_i) ^ fp16_sign(b_i);
  assign ea     = fp16_exp(a_i);
  assign eb     = fp16_exp(b_i);
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
  assign a_spec = (ea == 5'h1F);
  assign b_spec = (eb == 5'h1F);
  assign a_nan  = a_spec & (|fp16_mant(a_i));
  assign b_nan  = b_spec & (|fp16_mant(b_i));

  assign prod = {11'd0, 1'b1, fp16_mant(a_i)} * {11'd0, 1'b1, fp16_mant(b_i)};

  assign ea_s = signed'({5'd0, ea});
  assign eb_s = signed'({5'd0, eb});
  // Product of two [1,2) significands lies in [1,4); bit 21 set means one extra exponent step.
  assign exp_b  = ea_s + eb_s - 10'sd15 + (prod[21] ? 10'sd1 : 10'sd0);
  assign sig    = prod[21] ? prod[21:11] : prod[20:10];
  assign guard  = prod[21] ? prod[10] : prod[9];
  assign sticky = prod[21] ? (|prod[9:0]) : (|prod[8:0]);

  always_comb begin
    rp   = fp16_round_pack(sign, exp_b, sig, guard, sticky);
    p_o  = rp.val;
    of_o = rp.of;
    uf_o = rp.uf;
    if (a_nan || b_nan || (a_spec && b_zero) || (b_spec && a_zero)) begin
      p_o  = FP16_QNAN;
      of_o = 1'b0;
      uf_o = 1'b0;
    end else if (a_spec || b_spec) begin
      p_o  = {sign, FP16_POS_INF[14:0]};
      of_o = 1'b0;
      uf_o = 1'b0;
    end else if (a_zero || b_zero) begin
      p_o  = {sign, 15'd0};
      of_o = 1'b0;
      uf_o = 1'b0;
    end
  end

endmodule

// File: rtl/fast_inv_sqrt.sv
// fast_inv_sqrt: sequential FP16 reciprocal square root.
// Seeds y with the integer magic-constant trick and refines it with two Newton-Raphson steps
// on one shared FP16 multiplier. Special inputs bypass the refinement but keep the latency.
//   clk    : clock
//   reset  : synchronous active-high; clears state and arms a new computation
//   Xin    : FP16 operand, latched in the first cycle after reset falls
//   result : FP16 1/sqrt(Xin), valid while done is high
//   done   : result valid, held until the next reset
//   OFUF   : {overflow, underflow} sticky flags, valid with done
module fast_inv_sqrt
  import fpu16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Xin,
  output logic [15:0] result,
  output logic        done,
  output logic [1:0]  OFUF
);

  // 1.5 in fixed point with LSB weight 2^-24 (the LSB of the smallest normal).
  localparam logic signed [43:0] OneP5Fix = 44'sd25165824;

  state_e      state_q, state_d;
  logic [0:0]  iter_q, iter_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] h_q, h_d;
  logic [15:0] t_q, t_d;
  logic        bypass_q, bypass_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic [1:0]  ofuf_q, ofuf_d;

  logic [15:0] mul_a, mul_b, mul_p;
  logic        mul_of, mul_uf;

  logic [4:0]         in_exp, x_exp, t_exp;
  logic [43:0]        t_fix, mag, norm;
  logic signed [43:0] diff;
  logic [5:0]         msb;
  fp16_res_t          sub_res;

  fp16_mul u_mul (
    .a_i  (mul_a),
    .b_i  (mul_b),
    .p_o  (mul_p),
    .of_o (mul_of),
    .uf_o (mul_uf)
  );

  assign in_exp = fp16_exp(Xin);
  assign x_exp  = fp16_exp(x_q);

  // r = 1.5 - t done exactly in wide fixed point, then normalised and rounded once.
  always_comb begin
    t_exp = fp16_exp(t_q);
    t_fix = '0;
    if (t_exp != 5'd0) begin
      t_fix = {33'd0, 1'b1, fp16_mant(t_q)} << (t_exp - 5'd1);
    end
    diff = OneP5Fix - signed'(t_fix);
    mag  = diff[43] ? 44'(-diff) : 44'(diff);
    msb  = '0;
    for (int i = 0; i < 44; i++) begin
      if (mag[i]) msb = 6'(i);
    end
    norm    = mag << (6'd43 - msb);
    sub_res = fp16_round_pack(diff[43], signed'({4'd0, msb}) - 10'sd9, norm[43:33], norm[32],
                              |norm[31:0]);
    if (mag == '0) sub_res = '0;
  end

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    x_d      = x_q;
    y_d      = y_q;
    h_d      = h_q;
    t_d      = t_q;
    bypass_d = bypass_q;
    result_d = result_q;
    done_d   = done_q;
    ofuf_d   = ofuf_q;
    mul_a    = y_q;
    mul_b    = y_q;

    unique case (state_q)
      StLoad: begin
        x_d      = Xin;
        bypass_d = 1'b1;
        if (in_exp == 5'h1F && fp16_mant(Xin) != 10'd0) begin
          y_d    = FP16_QNAN;
          ofuf_d = 2'b11;
        end else if (in_exp == 5'd0) begin
          y_d    = FP16_POS_INF;
          ofuf_d = 2'b10;
        end else if (fp16_sign(Xin)) begin
          y_d    = FP16_QNAN;
          ofuf_d = 2'b11;
        end else if (in_exp == 5'h1F) begin
          y_d    = 16'h0000;
          ofuf_d = 2'b01;
        end else begin
          bypass_d = 1'b0;
        end
        state_d = StSeed;
      end
      StSeed: begin
        if (!bypass_q) begin
          y_d = INVSQRT_MAGIC - (x_q >> 1);
          // Halving the smallest normal exponent leaves the normal range.
          if (x_exp == 5'd1) begin
            h_d       = 16'h0000;
            ofuf_d[0] = 1'b1;
          end else begin
            h_d = {1'b0, x_exp - 5'd1, fp16_mant(x_q)};
          end
        end
        iter_d  = '0;
        state_d = StSq;
      end
      StSq: begin
        if (!bypass_q) begin
          t_d    = mul_p;
          ofuf_d = ofuf_q | {mul_of, mul_uf};
        end
        state_d = StMh;
      end
      StMh: begin
        mul_a = h_q;
        mul_b = t_q;
        if (!bypass_q) begin
          t_d    = mul_p;
          ofuf_d = ofuf_q | {mul_of, mul_uf};
        end
        state_d = StSub;
      end
      StSub: begin
        if (!bypass_q) begin
          t_d    = sub_res.val;
          ofuf_d = ofuf_q | {sub_res.of, sub_res.uf};
        end
        state_d = StMy;
      end
      StMy: begin
        mul_b = t_q;
        if (!bypass_q) begin
          y_d    = mul_p;
          ofuf_d = ofuf_q | {mul_of, mul_uf};
        end
        if (iter_q == 1'(NrIters - 1)) begin
          state_d = StFin;
        end else begin
          iter_d  = iter_q + 1'b1;
          state_d = StSq;
        end
      end
      StFin: begin
        result_d = y_q;
        done_d   = 1'b1;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StLoad;
      iter_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      h_q      <= '0;
      t_q      <= '0;
      bypass_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      ofuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      x_q      <= x_d;
      y_q      <= y_d;
      h_q      <= h_d;
      t_q      <= t_d;
      bypass_q <= bypass_d;
      result_q <= result_d;
      done_q   <= done_d;
      ofuf_q   <= ofuf_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign OFUF   = ofuf_q;

endmodule

// File: tb/tb_fast_inv_sqrt.sv
// Self-checking bench for fast_inv_sqrt: directed vectors, abort/reset and operand-toggle
// scenarios, and randomized operands checked against a real-arithmetic reference model.
module tb_fast_inv_sqrt;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Xin = 16'h0000;
  logic [15:0] result;
  logic        done;
  logic [1:0]  OFUF;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_of, m_uf;

  fast_inv_sqrt dut (
    .clk    (clk),
    .reset  (reset),
    .Xin    (Xin),
    .result (result),
    .done   (done),
    .OFUF   (OFUF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_near(input string tag, input logic [15:0] obs, input logic [15:0] ref_v,
                            input int tol);
    int d;
    d = int'(obs) - int'(ref_v);
    if (d < 0) d = -d;
    n_cmp++;
    assert (d <= tol) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected within %0d ulp of %h", tag, obs, tol, ref_v);
    end
  endtask

  function automatic real p2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [15:0] b);
    real v;
    if (b[14:10] == 5'd0) return 0.0;
    v = real'({1'b1, b[9:0]}) * p2(int'(b[14:10]) - 25);
    return b[15] ? -v : v;
  endfunction

  // Round an exact real to FP16 precision (RNE), flushing below-normal values to zero.
  function automatic real rnd(input real v);
    real  a, sc, fl, fr;
    int   e;
    logic s;
    if (v == 0.0) return 0.0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    sc = a * 1024.0;
    fl = $floor(sc);
    fr = sc - fl;
    if (fr > 0.5 || (fr == 0.5 && (int'(fl) % 2 == 1))) fl = fl + 1.0;
    if (fl >= 2048.0) begin fl = 1024.0; e++; end
    if (e < -14) begin m_uf = 1'b1; return 0.0; end
    if (e > 15) begin m_of = 1'b1; return s ? -1.0e6 : 1.0e6; end
    a = fl / 1024.0 * p2(e);
    return s ? -a : a;
  endfunction

  function automatic logic [15:0] to_bits(input real v);
    real  a;
    int   e, f;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a >= 65536.0) return {s, 15'h7C00};
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    f = int'(a * 1024.0) - 1024;
    return {s, 5'(e + 15), 10'(f)};
  endfunction

  task automatic model(input logic [15:0] x, output logic [15:0] res, output logic [1:0] fl);
    real y, h, t, r;
    logic [4:0] e;
    e = x[14:10];
    if (e == 5'h1F && x[9:0] != 10'd0) begin res = 16'h7E00; fl = 2'b11; end
    else if (e == 5'd0) begin res = 16'h7C00; fl = 2'b10; end
    else if (x[15]) begin res = 16'h7E00; fl = 2'b11; end
    else if (e == 5'h1F) begin res = 16'h0000; fl = 2'b01; end
    else begin
      m_of = 1'b0;
      m_uf = 1'b0;
      y = to_real(16'h59BB - {1'b0, x[15:1]});
      h = rnd(to_real(x) / 2.0);
      for (int k = 0; k < 2; k++) begin
        t = rnd(y * y);
        t = rnd(h * t);
        r = rnd(1.5 - t);
        y = rnd(y * r);
      end
      res = to_bits(y);
      fl  = {m_of, m_uf};
    end
  endtask

  task automatic start(input logic [15:0] x);
    @(negedge clk);
    Xin   = x;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
    check({tag, " latency"}, 16'(cyc), 16'd11);
  endtask

  task automatic run_check(input logic [15:0] x, input string tag);
    logic [15:0] er;
    logic [1:0]  ef;
    start(x);
    wait_done(tag);
    model(x, er, ef);
    check({tag, " result"}, result, er);
    check({tag, " OFUF"}, 16'(OFUF), 16'(ef));
  endtask

  initial begin
    logic [15:0] x, er, held;
    logic [1:0]  ef;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 16'h0000);
    check("reset done", 16'(done), 16'd0);
    check("reset OFUF", 16'(OFUF), 16'd0);

    // Directed vectors with independently known answers
    run_check(16'h3C00, "one");
    check("one const", result, 16'h3C00);
    run_check(16'h4400, "four");
    check("four const", result, 16'h3800);
    run_check(16'h0000, "pos zero");
    check("pos zero const", result, 16'h7C00);
    check("pos zero flags", 16'(OFUF), 16'd2);
    run_check(16'h8000, "neg zero");
    run_check(16'h0123, "subnormal");
    run_check(16'hC400, "negative");
    check("negative const", result, 16'h7E00);
    check("negative flags", 16'(OFUF), 16'd3);
    run_check(16'h7C00, "pos inf");
    check("pos inf flags", 16'(OFUF), 16'd1);
    run_check(16'h7E01, "nan");
    run_check(16'h0400, "min normal");
    run_check(16'h7BFF, "max normal");

    run_check(16'h50BB, "x37p8");
    check_near("x37p8 near", result, 16'h3133, 2);
    run_check(16'h4DE1, "x23p5");
    check_near("x23p5 near", result, 16'h3298, 2);
    held = result;
    repeat (4) @(posedge clk);
    #1;
    check("hold done", 16'(done), 16'd1);
    check("hold result", result, held);

    // Abort a run mid-way and restart with a new operand
    start(16'hC400);
    repeat (5) @(posedge clk);
    @(negedge clk);
    Xin   = 16'h4400;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort done", 16'(done), 16'd0);
    check("abort result", result, 16'h0000);
    check("abort OFUF", 16'(OFUF), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_done("restart");
    check("restart result", result, 16'h3800);
    check("restart OFUF", 16'(OFUF), 16'd0);

    // Operand changes after the load cycle must be ignored
    x = {1'b0, 5'(18), 10'h2A5};
    start(x);
    @(posedge clk);
    repeat (7) begin
      @(negedge clk);
      Xin = 16'($urandom);
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
    end
    check("toggle done", 16'(done), 16'd1);
    model(x, er, ef);
    check("toggle result", result, er);
    check("toggle OFUF", 16'(OFUF), 16'(ef));

    // Randomized operands: mostly positive normals, some arbitrary bit patterns
    for (int n = 0; n < 40; n++) begin
      if (n % 4 == 3) x = 16'($urandom);
      else x = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom)};
      run_check(x, $sformatf("rand %h", x));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
